panel_step_ctrl: RTL and testbench



---
 rtl/step_ctrl_pkg.sv | 19 +
 rtl/step_bp_match.sv | 32 +++
 rtl/panel_step_ctrl.sv | 76 +++++++
 tb/tb_panel_step_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: opcodes, state encodings and default widths for the step controller
package step_ctrl_pkg;
    localparam int DATA_W_DEF = 20;
    localparam int CNT_W_DEF  = 16;
    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_HALT     = 3'd1;
    localparam logic [2:0] OP_RUN      = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_RUN_N    = 3'd4;
    localparam logic [2:0] OP_SET_BP   = 3'd5;
    localparam logic [2:0] OP_SET_MASK = 3'd6;
    localparam logic [2:0] OP_CLR      = 3'd7;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RUN_N = 2'd2,
        ST_STEP  = 2'd3
    } state_e;
endpackage

// File: rtl/step_bp_match.sv
// step_bp_match: breakpoint value/mask/armed registers and skip-qualified masked compare
module step_bp_match import step_ctrl_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              set_val_i,
    input  logic              set_mask_i,
    input  logic              clr_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] arg_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              match_o
);
    logic [DATA_W-1:0] value_q, mask_q;
    logic              armed_q, skip_q;
    // skip masks the first cycle after any run entry so a run can leave a matching value
    assign match_o = armed_q & ((data_i & mask_q) == (value_q & mask_q)) & ~skip_q;
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            value_q <= '0;
            mask_q  <= '0;
            armed_q <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            skip_q  <= start_i;
            value_q <= set_val_i ? arg_i : value_q;
            mask_q  <= set_mask_i ? arg_i : mask_q;
            armed_q <= set_val_i ? 1'b1 : clr_i ? 1'b0 : armed_q;
        end
    end
endmodule

// File: rtl/panel_step_ctrl.sv
// panel_step_ctrl: run/halt/single-step sequencer gating a datapath via Step_en.
// Defining STEP_CTRL_PANEL_EN adds panel register/row declarations and a breakpoint lamp.
module panel_step_ctrl import step_ctrl_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Cmd_valid,
    output logic              Cmd_ready,
    input  logic [2:0]        Cmd_op,
    input  logic [DATA_W-1:0] Cmd_arg,
    input  logic [DATA_W-1:0] Data,
    output logic              Step_en,
    output logic [1:0]        State,
    output logic [CNT_W-1:0]  Steps,
    output logic              Bp_hit
);
    state_e           state_q;
    logic [CNT_W-1:0] steps_q, steps_d, remain_q, remain_d, run_len;
    logic             bp_hit_q, match, accept, running, redirect, start;
    assign run_len   = Cmd_arg[CNT_W-1:0];
    assign Cmd_ready = state_q != ST_STEP;
    assign accept    = Cmd_valid & Cmd_ready;
    assign running   = state_q != ST_IDLE;
    assign Step_en   = running & ~match;
    assign redirect  = accept & (Cmd_op inside {OP_HALT, OP_RUN, OP_STEP, OP_RUN_N});
    assign start     = accept & (Cmd_op inside {OP_RUN, OP_STEP, OP_RUN_N});
    assign State     = state_q;
    assign Steps     = steps_q;
    assign Bp_hit    = bp_hit_q;
    step_bp_match #(.DATA_W(DATA_W)) u_bp (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .set_val_i  (accept && Cmd_op == OP_SET_BP),
        .set_mask_i (accept && Cmd_op == OP_SET_MASK),
        .clr_i      (accept && Cmd_op == OP_CLR),
        .start_i    (start),
        .arg_i      (Cmd_arg),
        .data_i     (Data),
        .match_o    (match)
    );
    always_comb begin
        steps_d  = (accept && Cmd_op == OP_CLR) ? '0 : steps_q + CNT_W'(Step_en);
        remain_d = (accept && Cmd_op == OP_RUN_N) ? run_len
                 : remain_q - CNT_W'(Step_en && state_q == ST_RUN_N);
    end
    // State-changing commands override breakpoint, expiry and step completion
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            steps_q  <= '0;
            remain_q <= '0;
            bp_hit_q <= 1'b0;
        end else begin
            steps_q  <= steps_d;
            remain_q <= remain_d;
            bp_hit_q <= 1'b0;
            if (redirect)
                state_q <= Cmd_op == OP_RUN ? ST_RUN
                         : Cmd_op == OP_STEP ? ST_STEP
                         : (Cmd_op == OP_RUN_N && run_len != '0) ? ST_RUN_N : ST_IDLE;
            else if (running && match) begin
                state_q  <= ST_IDLE;
                bp_hit_q <= 1'b1;
            end else if (state_q == ST_STEP || (state_q == ST_RUN_N && remain_q == CNT_W'(1)))
                state_q <= ST_IDLE;
        end
    end
`ifdef STEP_CTRL_PANEL_EN
    logic hit_seen_q, bp_lamp;
    always_ff @(posedge Clk)
        hit_seen_q <= !Reset_n ? 1'b0 : bp_hit_q ? 1'b1 : running ? 1'b0 : hit_seen_q;
    assign bp_lamp = bp_hit_q | (state_q == ST_IDLE & hit_seen_q);
`endif
endmodule

// File: tb/tb_panel_step_ctrl.sv
// tb_panel_step_ctrl: directed checks of the step controller driving a 20-bit shift/XOR pattern
module tb_panel_step_ctrl;
    import step_ctrl_pkg::*;
    logic        Clk = 1'b0, Reset_n = 1'b0, Cmd_valid = 1'b0, seed = 1'b0;
    logic [2:0]  Cmd_op = 3'd0;
    logic [19:0] Cmd_arg = '0, pat = 20'd1;
    logic        Cmd_ready, Step_en, Bp_hit, r4, e4, b4;
    logic [1:0]  State, s4;
    logic [15:0] Steps;
    logic [3:0]  n4;
    int ncmp = 0, nfail = 0, en_cnt = 0, e0 = 0, n = 0;

    panel_step_ctrl u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
        .Cmd_op(Cmd_op), .Cmd_arg(Cmd_arg), .Data(pat), .Step_en(Step_en),
        .State(State), .Steps(Steps), .Bp_hit(Bp_hit)
    );
    panel_step_ctrl #(.CNT_W(4)) u_dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .Cmd_valid(Cmd_valid), .Cmd_ready(r4),
        .Cmd_op(Cmd_op), .Cmd_arg(Cmd_arg), .Data(pat), .Step_en(e4),
        .State(s4), .Steps(n4), .Bp_hit(b4)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk)
        if (seed) pat <= 20'd1;
        else if (Step_en) pat <= {pat[18:0], pat[19] ^ pat[16]};
    always @(negedge Clk) if (Step_en) en_cnt <= en_cnt + 1;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask
    task automatic cmd(input logic [2:0] op, input logic [19:0] arg);
        Cmd_valid = 1'b1;
        Cmd_op = op;
        Cmd_arg = arg;
        cyc();
        Cmd_valid = 1'b0;
        Cmd_op = OP_NOP;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_idle(input int lim, input string tag);
        int k = 0;
        while (State != 2'd0 && k < lim) begin cyc(); k++; end
        chk(tag, 32'(State), 0);
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_state", 32'(State), 0);
        chk("rst_step_en", 32'(Step_en), 0);
        Reset_n = 1'b1;
        cyc();
        chk("rst_steps", 32'(Steps), 0);
        chk("rst_ready", 32'(Cmd_ready), 1);
        chk("rst_bp_hit", 32'(Bp_hit), 0);
        e0 = en_cnt;
        repeat (5) cyc();
        chk("idle_no_steps", 32'(en_cnt - e0), 0);
        // three single steps
        e0 = en_cnt;
        for (int i = 0; i < 3; i++) begin
            cmd(OP_STEP, 20'd0);
            chk("step_state", 32'(State), 3);
            chk("step_ready", 32'(Cmd_ready), 0);
            chk("step_en", 32'(Step_en), 1);
            cyc();
            chk("step_done", 32'(State), 0);
        end
        chk("step_count", 32'(en_cnt - e0), 3);
        chk("step_steps", 32'(Steps), 3);
        // RUN_N 10 from seed 1
        seed = 1'b1;
        cyc();
        seed = 1'b0;
        chk("seed", 32'(pat), 1);
        e0 = en_cnt;
        cmd(OP_RUN_N, 20'd10);
        chk("runn_state", 32'(State), 2);
        wait_idle(30, "runn_idle");
        chk("runn_count", 32'(en_cnt - e0), 10);
        chk("runn_steps", 32'(Steps), 13);
        chk("runn_pat", 32'(pat), 32'h400);
        e0 = en_cnt;
        cmd(OP_RUN_N, 20'd0);
        chk("runn0_state", 32'(State), 0);
        chk("runn0_en", 32'(Step_en), 0);
        cyc();
        chk("runn0_count", 32'(en_cnt - e0), 0);
        chk("runn0_steps", 32'(Steps), 13);
        // breakpoint at 7th pattern value
        cmd(OP_CLR, 20'd0);
        chk("clr_steps", 32'(Steps), 0);
        seed = 1'b1;
        cmd(OP_SET_MASK, 20'hFFFFF);
        seed = 1'b0;
        cmd(OP_SET_BP, 20'h80);
        cmd(OP_RUN, 20'd0);
        n = 0;
        while (!Bp_hit && n < 30) begin cyc(); n++; end
        chk("bp_hit", 32'(Bp_hit), 1);
        chk("bp_state", 32'(State), 0);
        chk("bp_data", 32'(pat), 32'h80);
        chk("bp_steps", 32'(Steps), 7);
        cyc();
        chk("bp_pulse", 32'(Bp_hit), 0);
        chk("bp_held", 32'(pat), 32'h80);
        cmd(OP_RUN, 20'd0);
        chk("bp_skip_en", 32'(Step_en), 1);
        cyc();
        chk("bp_leave", 32'(pat), 32'h100);
        chk("bp_rerun", 32'(State), 1);
        // HALT coinciding with a match
        cmd(OP_HALT, 20'd0);
        chk("halt_state", 32'(State), 0);
        seed = 1'b1;
        cmd(OP_SET_BP, 20'h8);
        seed = 1'b0;
        cmd(OP_RUN, 20'd0);
        n = 0;
        while (pat != 20'h8 && n < 10) begin cyc(); n++; end
        chk("hm_reach", 32'(pat), 32'h8);
        chk("hm_match_en", 32'(Step_en), 0);
        cmd(OP_HALT, 20'd0);
        chk("hm_state", 32'(State), 0);
        chk("hm_no_hit", 32'(Bp_hit), 0);
        cyc();
        chk("hm_no_hit2", 32'(Bp_hit), 0);
        chk("hm_held", 32'(pat), 32'h8);
        // reset in the middle of RUN_N 100
        cmd(OP_CLR, 20'd0);
        cmd(OP_RUN_N, 20'd100);
        n = 0;
        while (Steps != 16'd40 && n < 60) begin cyc(); n++; end
        chk("mid_steps", 32'(Steps), 40);
        chk("mid_state", 32'(State), 2);
        Reset_n = 1'b0;
        cyc();
        chk("mrst_state", 32'(State), 0);
        chk("mrst_en", 32'(Step_en), 0);
        chk("mrst_steps", 32'(Steps), 0);
        chk("mrst_ready", 32'(Cmd_ready), 1);
        chk("mrst_bp", 32'(Bp_hit), 0);
        Reset_n = 1'b1;
        cyc();
        chk("mrst_en2", 32'(Step_en), 0);
        // 4-bit counter wrap
        cmd(OP_RUN_N, 20'd15);
        wait_idle(30, "wrap_idle");
        chk("wrap_15", 32'(n4), 15);
        chk("wrap_state4", 32'(s4), 0);
        cmd(OP_STEP, 20'd0);
        cyc();
        chk("wrap_0", 32'(n4), 0);
        chk("wrap_main", 32'(Steps), 16);
        // CLR in a stepping cycle
        cmd(OP_RUN, 20'd0);
        cyc();
        cyc();
        chk("clr_run_en", 32'(Step_en), 1);
        cmd(OP_CLR, 20'd0);
        chk("clr_wins", 32'(Steps), 0);
        chk("clr_keeps_run", 32'(State), 1);
        cyc();
        chk("clr_then_inc", 32'(Steps), 1);
        cmd(OP_HALT, 20'd0);
        chk("final_idle", 32'(State), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
